probe_uplink_arbiter: RTL and testbench



---
 rtl/probe_uplink_pkg.sv | 26 ++
 rtl/probe_uplink_arbiter_if.sv | 26 ++
 rtl/probe_uplink_fifo.sv | 54 +++++
 rtl/probe_uplink_arbiter.sv | 137 +++++++++++++
 tb/tb_probe_uplink_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/probe_uplink_pkg.sv
// Shared definitions for the probe uplink arbiter: FSM encoding and header layout.
// Must stay in sync with the probe command/encoding defines and SerialProbeXactor.
package probe_uplink_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    BODY    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam int WordWidth   = 32;
  localparam int HdrIdMsb    = 31;
  localparam int HdrIdLsb    = 16;
  localparam int HdrCountMsb = 15;
  localparam int HdrCountLsb = 0;

  function automatic logic [15:0] hdr_count(input logic [WordWidth-1:0] w);
    return w[HdrCountMsb:HdrCountLsb];
  endfunction

  function automatic logic [15:0] hdr_id(input logic [WordWidth-1:0] w);
    return w[HdrIdMsb:HdrIdLsb];
  endfunction

endpackage

// File: rtl/probe_uplink_arbiter_if.sv
// Probe-side and uplink-side signals of the arbiter; slave is the arbiter's view.
interface probe_uplink_arbiter_if #(
  parameter int NumProbes = 4
);
  import probe_uplink_pkg::*;

  logic [WordWidth*NumProbes-1:0] DATAUP;
  logic [NumProbes-1:0]           DATAVALID;
  logic [NumProbes-1:0]           DELAY;
  logic [NumProbes-1:0]           ACK;
  logic [WordWidth-1:0]           OUTDATA;
  logic                           OUTLAST;
  logic                           OUTVALID;
  logic                           OUTREADY;

  modport slave (
    input  DATAUP, DATAVALID, DELAY, OUTREADY,
    output ACK, OUTDATA, OUTLAST, OUTVALID
  );

  modport master (
    output DATAUP, DATAVALID, DELAY, OUTREADY,
    input  ACK, OUTDATA, OUTLAST, OUTVALID
  );

endinterface

// File: rtl/probe_uplink_fifo.sv
// Fall-through FIFO; head is combinational from storage and reads zero while empty.
module probe_uplink_fifo #(
  parameter int Width     = 33,
  parameter int Depth     = 8,
  parameter int AddrWidth = 3
) (
  input  logic             UCLK,
  input  logic             URST,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  logic [Width-1:0]     mem_q [Depth];
  logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AddrWidth:0]   count_q, count_d;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == (AddrWidth+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // NOTE: storage has no reset; validity is tracked by count_q and empty reads are masked.
  always_ff @(posedge UCLK) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge UCLK or negedge URST) begin
    if (!URST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/probe_uplink_arbiter.sv
// Round-robin merge of NumProbes probe dump streams onto one 32-bit uplink,
// forwarding whole packets (header + counted body) with the last word tagged.
module probe_uplink_arbiter
  import probe_uplink_pkg::*;
#(
  parameter int NumProbes     = 4,
  parameter int FifoDepth     = 8,
  parameter int FifoAddrWidth = 3
) (
  input  logic                    UCLK,
  input  logic                    URST,
  probe_uplink_arbiter_if.slave   up
);

  localparam int IdxW = (NumProbes > 1) ? $clog2(NumProbes) : 1;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        grant_q, grant_d;
  logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [15:0]            word_cnt_q, word_cnt_d;

  logic [NumProbes-1:0]   req;
  logic [WordWidth-1:0]   words [NumProbes];
  logic [WordWidth-1:0]   cur_word;
  logic                   found;
  logic [IdxW-1:0]        pick;
  logic [IdxW:0]          scan;
  logic                   push, push_last;
  logic [NumProbes-1:0]   ack;
  logic                   fifo_full, fifo_empty;
  logic [WordWidth:0]     fifo_head;

  assign req = up.DATAVALID & up.DELAY;

  always_comb begin
    for (int i = 0; i < NumProbes; i++) words[i] = up.DATAUP[i*WordWidth +: WordWidth];
  end
  assign cur_word = words[grant_q];

  // First requester at or after rr_ptr_q, wrapping modulo NumProbes.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr_q;
    scan  = '0;
    for (int k = 0; k < NumProbes; k++) begin
      scan = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
      if (scan >= (IdxW+1)'(NumProbes)) scan = scan - (IdxW+1)'(NumProbes);
      if (!found && req[scan[IdxW-1:0]]) begin
        found = 1'b1;
        pick  = scan[IdxW-1:0];
      end
    end
  end

  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    word_cnt_d = word_cnt_q;
    push       = 1'b0;
    push_last  = 1'b0;
    ack        = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (up.DATAVALID[grant_q] && !fifo_full) begin
          push          = 1'b1;
          ack[grant_q]  = 1'b1;
          word_cnt_d    = hdr_count(cur_word);
          if (hdr_count(cur_word) == 16'd0) begin
            push_last = 1'b1;
            state_d   = RELEASE;
          end else begin
            state_d   = BODY;
          end
        end
      end
      BODY: begin
        if (up.DATAVALID[grant_q] && !fifo_full) begin
          push         = 1'b1;
          ack[grant_q] = 1'b1;
          word_cnt_d   = word_cnt_q - 16'd1;
          if (word_cnt_q == 16'd1) begin
            push_last = 1'b1;
            state_d   = RELEASE;
          end
        end
      end
      RELEASE: begin
        rr_ptr_d = (grant_q == IdxW'(NumProbes - 1)) ? '0 : grant_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge UCLK or negedge URST) begin
    if (!URST) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  probe_uplink_fifo #(
    .Width     (WordWidth + 1),
    .Depth     (FifoDepth),
    .AddrWidth (FifoAddrWidth)
  ) u_fifo (
    .UCLK        (UCLK),
    .URST        (URST),
    .push_i      (push),
    .push_data_i ({push_last, cur_word}),
    .pop_i       (up.OUTREADY),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  assign up.ACK      = ack;
  assign up.OUTDATA  = fifo_head[WordWidth-1:0];
  assign up.OUTLAST  = fifo_head[WordWidth];
  assign up.OUTVALID = !fifo_empty;

endmodule

// File: tb/tb_probe_uplink_arbiter.sv
// Bench for probe_uplink_arbiter: behavioural probes feed per-probe word queues,
// expected uplink words go to a scoreboard and are compared as they leave the FIFO.
module tb_probe_uplink_arbiter;
  import probe_uplink_pkg::*;

  localparam int NP  = 4;
  localparam int FD  = 8;
  localparam int FAW = 3;

  logic UCLK = 1'b0;
  logic URST = 1'b0;
  always #5 UCLK = ~UCLK;

  probe_uplink_arbiter_if #(.NumProbes(NP)) bus ();

  probe_uplink_arbiter #(
    .NumProbes     (NP),
    .FifoDepth     (FD),
    .FifoAddrWidth (FAW)
  ) dut (
    .UCLK (UCLK),
    .URST (URST),
    .up   (bus)
  );

  typedef struct {
    int probe;
    int count;
    int exp_acks;
    int exp_rr;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] pq [NP][$];
  logic [32:0] sb [$];
  bit          gap [NP];
  int          ack_total [NP];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge UCLK);
    #2;
  endtask

  task automatic drive_probes();
    for (int i = 0; i < NP; i++) begin
      bus.DATAVALID[i]       = (pq[i].size() > 0) && !gap[i];
      bus.DELAY[i]           = (pq[i].size() > 0);
      bus.DATAUP[32*i +: 32] = (pq[i].size() > 0) ? pq[i][0] : 32'h0;
    end
  endtask

  task automatic load_packet(input int p, input int cnt, input int tag);
    logic [31:0] w;
    w = {16'(p), 16'(cnt)};
    pq[p].push_back(w);
    sb.push_back({cnt == 0, w});
    for (int j = 1; j <= cnt; j++) begin
      w = {4'hB, 4'(p), 8'(tag), 16'(j)};
      pq[p].push_back(w);
      sb.push_back({j == cnt, w});
    end
  endtask

  function automatic bit probes_busy();
    bit b = 1'b0;
    for (int i = 0; i < NP; i++) if (pq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || probes_busy() || dut.state_q != IDLE) && n < budget) begin
      step();
      n++;
    end
    check("drain_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  // Probe models and output monitor: sample at negedge, react just after posedge.
  initial begin
    logic [NP-1:0] ack_s;
    logic [32:0]   e;
    forever begin
      @(negedge UCLK);
      ack_s = bus.ACK;
      if (URST) check("ack_onehot0", 64'($onehot0(ack_s)), 64'd1);
      if (bus.OUTVALID && bus.OUTREADY) begin
        e = (sb.size() > 0) ? sb.pop_front() : 33'bx;
        check("out_word", 64'({bus.OUTLAST, bus.OUTDATA}), 64'(e));
      end
      @(posedge UCLK);
      #1;
      for (int i = 0; i < NP; i++) begin
        if (ack_s[i] && pq[i].size() > 0) begin
          void'(pq[i].pop_front());
          ack_total[i]++;
        end
      end
      drive_probes();
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt [4];
    int   base, n, snap;

    vt[0] = '{probe: 2, count: 0, exp_acks: 1, exp_rr: 3};
    vt[1] = '{probe: 3, count: 1, exp_acks: 2, exp_rr: 0};
    vt[2] = '{probe: 1, count: 5, exp_acks: 6, exp_rr: 2};
    vt[3] = '{probe: 0, count: 2, exp_acks: 3, exp_rr: 1};

    for (int i = 0; i < NP; i++) begin
      gap[i] = 1'b0;
      ack_total[i] = 0;
    end
    bus.OUTREADY = 1'b0;
    drive_probes();
    repeat (3) step();

    check("rst_outvalid", 64'(bus.OUTVALID), 64'd0);
    check("rst_ack",      64'(bus.ACK),      64'd0);
    check("rst_outdata",  64'(bus.OUTDATA),  64'd0);
    check("rst_outlast",  64'(bus.OUTLAST),  64'd0);
    check("rst_state",    64'(dut.state_q),  64'(IDLE));
    check("rst_rr",       64'(dut.rr_ptr_q), 64'd0);
    check("rst_grant",    64'(dut.grant_q),  64'd0);
    URST = 1'b1;
    step();

    // Contention: probes 1 and 3 both queued; expected order 1,3,1,3,1.
    bus.OUTREADY = 1'b1;
    load_packet(1, 2, 1);
    load_packet(3, 3, 2);
    load_packet(1, 1, 3);
    load_packet(3, 0, 4);
    load_packet(1, 2, 5);
    wait_drain(300);
    check("cont_acks_p1", 64'(ack_total[1]), 64'd8);
    check("cont_acks_p3", 64'(ack_total[3]), 64'd5);
    check("cont_rr",      64'(dut.rr_ptr_q), 64'd2);

    // Single packet on probe 0: 4 ACKs, RELEASE then IDLE after the last push.
    base = ack_total[0];
    load_packet(0, 3, 6);
    n = 0;
    for (int c = 0; c < 50 && n < 4; c++) begin
      step();
      if (bus.ACK[0]) n++;
    end
    check("single_ack_pulses", 64'(n), 64'd4);
    step();
    check("single_release", 64'(dut.state_q), 64'(RELEASE));
    step();
    check("single_idle",    64'(dut.state_q), 64'(IDLE));
    wait_drain(50);
    check("single_acks",    64'(ack_total[0] - base), 64'd4);
    check("single_rr",      64'(dut.rr_ptr_q), 64'd1);

    for (int v = 0; v < 4; v++) begin
      base = ack_total[vt[v].probe];
      load_packet(vt[v].probe, vt[v].count, 10 + v);
      wait_drain(100);
      check("vec_acks", 64'(ack_total[vt[v].probe] - base), 64'(vt[v].exp_acks));
      check("vec_rr",   64'(dut.rr_ptr_q), 64'(vt[v].exp_rr));
    end

    // Backpressure: 10-word body against an 8-entry FIFO.
    bus.OUTREADY = 1'b0;
    base = ack_total[0];
    load_packet(0, 10, 20);
    repeat (30) step();
    check("bp_fifo_count", 64'(dut.u_fifo.count_q), 64'd8);
    check("bp_acks",       64'(ack_total[0] - base), 64'd8);
    check("bp_ack_held",   64'(bus.ACK), 64'd0);
    check("bp_state",      64'(dut.state_q), 64'(BODY));
    bus.OUTREADY = 1'b1;
    wait_drain(100);
    check("bp_total_acks", 64'(ack_total[0] - base), 64'd11);

    // DATAVALID gap of 3 cycles inside the body.
    base = ack_total[0];
    load_packet(0, 6, 30);
    for (int c = 0; c < 50 && (ack_total[0] - base) < 3; c++) step();
    gap[0] = 1'b1;
    step();
    snap = ack_total[0];
    for (int c = 0; c < 3; c++) begin
      check("gap_ack",   64'(bus.ACK), 64'd0);
      check("gap_grant", 64'(dut.grant_q), 64'd0);
      check("gap_state", 64'(dut.state_q), 64'(BODY));
      step();
      check("gap_no_consume", 64'(ack_total[0]), 64'(snap));
    end
    gap[0] = 1'b0;
    wait_drain(100);
    check("gap_total_acks", 64'(ack_total[0] - base), 64'd7);

    // Asynchronous reset during BODY with 5 FIFO entries.
    bus.OUTREADY = 1'b0;
    load_packet(0, 10, 40);
    for (int c = 0; c < 50 && dut.u_fifo.count_q != 5; c++) step();
    check("mid_fifo_count", 64'(dut.u_fifo.count_q), 64'd5);
    URST = 1'b0;
    #1;
    check("mid_rst_ack",      64'(bus.ACK), 64'd0);
    check("mid_rst_outvalid", 64'(bus.OUTVALID), 64'd0);
    check("mid_rst_state",    64'(dut.state_q), 64'(IDLE));
    for (int i = 0; i < NP; i++) pq[i].delete();
    sb.delete();
    step();
    step();
    URST = 1'b1;
    step();
    check("post_rst_state", 64'(dut.state_q), 64'(IDLE));
    bus.OUTREADY = 1'b1;
    base = ack_total[2];
    load_packet(2, 2, 50);
    wait_drain(100);
    check("post_rst_acks", 64'(ack_total[2] - base), 64'd3);
    check("post_rst_rr",   64'(dut.rr_ptr_q), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
